// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer: per-channel 2-FF synchroniser, symmetric debounce
// counter and hold FSM producing press/release/long_press/repeat pulses.
module multi_button_debouncer #(
  parameter int   N             = 4,
  parameter logic ACTIVE        = 1'b1,
  parameter int   LIMIT         = 1_000_000,
  parameter int   LONG_LIMIT    = 100_000_000,
  parameter int   REPEAT_PERIOD = 20_000_000,
  parameter bit   REPEAT_EN     = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] noise_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_press_o,
  output logic [N-1:0] repeat_o
);

  localparam int MAX_AB = (LIMIT > LONG_LIMIT) ? LIMIT : LONG_LIMIT;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LIMIT_C  = CW'(LIMIT);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_LIMIT - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_e;

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  // Two-stage synchroniser; idle level is loaded on reset so nothing looks pressed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= {N{~ACTIVE}};
      sync_q <= {N{~ACTIVE}};
    end else begin
      meta_q <= noise_i;
      sync_q <= meta_q;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          stable_q, stable_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    hold_state_e   state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          mismatch_s;

    assign mismatch_s = ((sync_q[g] == ACTIVE) != stable_q);

    // Debounce counter and stable-state toggle with edge pulse generation.
    always_comb begin
      stable_d  = stable_q;
      dcnt_d    = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (mismatch_s) begin
        if (dcnt_q == LIMIT_C) begin
          stable_d  = ~stable_q;
          press_d   = ~stable_q;
          release_d = stable_q;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end else begin
        dcnt_d = '0;
      end
    end

    // Hold FSM; an accepted release overrides any long/repeat boundary in the same cycle.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      if (release_d) begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            hcnt_d = '0;
            if (press_d) begin
              state_d = ST_HELD;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_HELD: begin
            if (hcnt_q == LONG_END) begin
              state_d = ST_LONG;
              long_d  = 1'b1;
              hcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + CW'(1);
            end
          end
          ST_LONG: begin
            if (REPEAT_EN && (hcnt_q == REP_END)) begin
              rep_d  = 1'b1;
              hcnt_d = '0;
            end else if (REPEAT_EN) begin
              hcnt_d = hcnt_q + CW'(1);
            end else begin
              hcnt_d = '0;
            end
          end
          default: begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end
        endcase
      end
    end

    // Per-channel state and registered pulse outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        stable_q  <= 1'b0;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        state_q   <= ST_IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rep_q     <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        state_q   <= state_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        rep_q     <= rep_d;
      end
    end

    assign level_o[g]      = stable_q;
    assign press_o[g]      = press_q;
    assign release_o[g]    = release_q;
    assign long_press_o[g] = long_q;
    assign repeat_o[g]     = rep_q;
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with N=2, LIMIT=4, LONG_LIMIT=10,
// REPEAT_PERIOD=3; a second instance is built with ACTIVE=0.
module tb_multi_button_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] noise = 2'b00;
  logic [1:0] noise_lo = 2'b11;
  logic [1:0] level, press, rel, longp, rep;
  logic [1:0] level_lo, press_lo, rel_lo, longp_lo, rep_lo;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_button_debouncer #(
    .N(2), .ACTIVE(1'b1), .LIMIT(4), .LONG_LIMIT(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .noise_i(noise),
    .level_o(level), .press_o(press), .release_o(rel),
    .long_press_o(longp), .repeat_o(rep)
  );

  multi_button_debouncer #(
    .N(2), .ACTIVE(1'b0), .LIMIT(4), .LONG_LIMIT(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1)
  ) dut_lo (
    .clk_i(clk), .reset_i(reset), .noise_i(noise_lo),
    .level_o(level_lo), .press_o(press_lo), .release_o(rel_lo),
    .long_press_o(longp_lo), .repeat_o(rep_lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    noise = 2'b00;
    noise_lo = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] all_o;
    all_o = {level, press, rel, longp, rep};
    n_checks++;
    if (all_o !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", all_o, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      all_o = {level_lo, press_lo, rel_lo, longp_lo, rep_lo};
      n_checks++;
      if (all_o !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_idle_lo edge %0d: got %b expected %b", k, all_o, 10'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    noise = 2'b01;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_checks++;
      if (level !== ((e >= 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL clean_level edge %0d: got %b expected %b", e, level, (e >= 6) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (press !== ((e == 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %b expected %b", e, press, (e == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 0; e <= 14; e++) begin
      noise = {1'b0, ((e < 3) || (e >= 5))};
      tick();
      n_checks++;
      if (press !== ((e == 11) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL bounce_press edge %0d: got %b expected %b", e, press, (e == 11) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (level !== ((e >= 11) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL bounce_level edge %0d: got %b expected %b", e, level, (e >= 11) ? 2'b01 : 2'b00);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_long_hold();
    int n_rep;
    logic exp_rep;
    n_rep = 0;
    do_reset();
    // press lands at edge 6; the release sample is timed so release lands on the fifth repeat slot
    for (int e = 0; e <= 40; e++) begin
      noise = {1'b0, (e < 25)};
      tick();
      exp_rep = (e == 19) || (e == 22) || (e == 25) || (e == 28);
      if (rep[0]) n_rep++;
      n_checks++;
      if (press !== ((e == 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL long_press_pulse edge %0d: got %b expected %b", e, press, (e == 6) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (longp !== ((e == 16) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL long_longp edge %0d: got %b expected %b", e, longp, (e == 16) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (rep !== {1'b0, exp_rep}) begin
        n_fail++;
        $display("FAIL long_repeat edge %0d: got %b expected %b", e, rep, {1'b0, exp_rep});
      end
      n_checks++;
      if (rel !== ((e == 31) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL long_release edge %0d: got %b expected %b", e, rel, (e == 31) ? 2'b01 : 2'b00);
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_rep !== 4) begin
      n_fail++;
      $display("FAIL long_repeat_count: got %0d expected %0d", n_rep, 4);
    end
  endtask

  task automatic test_short_hold();
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      noise = {(e < 5), 1'b0};
      tick();
      n_checks++;
      if (press !== ((e == 6) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL short_press edge %0d: got %b expected %b", e, press, (e == 6) ? 2'b10 : 2'b00);
      end
      n_checks++;
      if (rel !== ((e == 11) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL short_release edge %0d: got %b expected %b", e, rel, (e == 11) ? 2'b10 : 2'b00);
      end
      n_checks++;
      if ({longp, rep} !== 4'b0000) begin
        n_fail++;
        $display("FAIL short_long_rep edge %0d: got %b expected %b", e, {longp, rep}, 4'b0000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    noise = 2'b11;
    noise_lo = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_checks++;
      if ({press, level} !== ((e == 6) ? 4'b1111 : ((e > 6) ? 4'b0011 : 4'b0000))) begin
        n_fail++;
        $display("FAIL simul_press edge %0d: got %b expected %b", e, {press, level},
                 (e == 6) ? 4'b1111 : ((e > 6) ? 4'b0011 : 4'b0000));
      end
      n_checks++;
      if ({press_lo, level_lo} !== ((e == 6) ? 4'b1111 : ((e > 6) ? 4'b0011 : 4'b0000))) begin
        n_fail++;
        $display("FAIL active_low_press edge %0d: got %b expected %b", e, {press_lo, level_lo},
                 (e == 6) ? 4'b1111 : ((e > 6) ? 4'b0011 : 4'b0000));
      end
    end
    @(negedge clk);
    noise = 2'b00;
    noise_lo = 2'b11;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_checks++;
      if ({rel, rel_lo} !== ((e == 6) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL simul_release edge %0d: got %b expected %b", e, {rel, rel_lo},
                 (e == 6) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] all_o;
    do_reset();
    noise = 2'b01;
    repeat (5) tick();  // edges 0..4, debounce count now at 3
    #2;
    reset = 1'b1;
    #1;
    all_o = {level, press, rel, longp, rep};
    n_checks++;
    if (all_o !== 10'b0) begin
      n_fail++;
      $display("FAIL abort_debounce_outputs: got %b expected %b", all_o, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      tick();
      n_checks++;
      if (press !== ((e == 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL abort_repress edge %0d: got %b expected %b", e, press, (e == 6) ? 2'b01 : 2'b00);
      end
      n_checks++;
      if (longp !== ((e == 16) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL abort_longp edge %0d: got %b expected %b", e, longp, (e == 16) ? 2'b01 : 2'b00);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    all_o = {level, press, rel, longp, rep};
    n_checks++;
    if (all_o !== 10'b0) begin
      n_fail++;
      $display("FAIL abort_long_outputs: got %b expected %b", all_o, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_checks++;
      if ({press, rel, rep} !== ((e == 6) ? 6'b010000 : 6'b000000)) begin
        n_fail++;
        $display("FAIL abort_long_repress edge %0d: got %b expected %b", e, {press, rel, rep},
                 (e == 6) ? 6'b010000 : 6'b000000);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_short_hold();
    test_simultaneous();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
